// File: rtl/pipeline_step_ctrl.sv
// rtl/pipeline_step_ctrl.sv - IF/ID/EX step/run sequencer with debounced buttons; optional adv counter via PIPE_ADV_COUNT_EN

module pipeline_step_deb #(
    parameter int DEB_CYCLES = 16
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic pulse
);
    localparam int CW = $clog2(DEB_CYCLES + 1);

    logic          s0;
    logic          s1;
    logic          s_prev;
    logic          lvl;
    logic [CW-1:0] cnt;

    // Synchronize, time the stable period, accept the level and flag an accepted rising edge
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            s0     <= 1'b0;
            s1     <= 1'b0;
            s_prev <= 1'b0;
            lvl    <= 1'b0;
            cnt    <= '0;
            pulse  <= 1'b0;
        end else begin
            s0     <= btn;
            s1     <= s0;
            s_prev <= s1;
            pulse  <= 1'b0;
            if (s1 != s_prev) begin
                cnt <= '0;
            end else if (cnt != CW'(DEB_CYCLES - 1)) begin
                cnt <= cnt + 1'b1;
            end else if (lvl != s1) begin
                lvl   <= s1;
                pulse <= s1;
            end
        end
    end
endmodule

module pipeline_step_ctrl #(
    parameter int DEB_CYCLES = 16,
    parameter int PC_W       = 4
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            btn_step,
    input  logic            btn_run,
    input  logic            bp_en,
    input  logic [PC_W-1:0] bp_addr,
    input  logic            hazard,
    input  logic            jmp_valid,
    input  logic [PC_W-1:0] jmp_addr,
    output logic [PC_W-1:0] pc,
    output logic            if_en,
    output logic            id_en,
    output logic            ex_en,
    output logic            id_flush,
    output logic            ex_bubble,
    output logic            running,
    output logic            halted,
    output logic [15:0]     adv_count
);
    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        HALT = 2'd2
    } state_t;

    state_t          state;
    state_t          state_nxt;
    logic            step_pulse;
    logic            run_pulse;
    logic            skip_bp;
    logic            adv;
    logic [PC_W-1:0] pc_nxt;

    pipeline_step_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_step (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_step),
        .pulse (step_pulse)
    );

    pipeline_step_deb #(.DEB_CYCLES(DEB_CYCLES)) u_deb_run (
        .clk   (clk),
        .rst_n (rst_n),
        .btn   (btn_run),
        .pulse (run_pulse)
    );

    // Decide whether the pipeline advances this cycle and where the FSM goes; run beats step
    always_comb begin
        adv       = 1'b0;
        state_nxt = state;
        case (state)
            IDLE: begin
                if (run_pulse)       state_nxt = RUN;
                else if (step_pulse) adv = 1'b1;
            end
            RUN: begin
                if (run_pulse)                                state_nxt = IDLE;
                else if (bp_en && pc == bp_addr && !skip_bp)  state_nxt = HALT;
                else                                          adv = 1'b1;
            end
            HALT: begin
                if (run_pulse) begin
                    state_nxt = RUN;
                end else if (step_pulse) begin
                    adv       = 1'b1;
                    state_nxt = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
    end

    // Stage controls: a jump squashes ID and overrides a hazard; a hazard freezes IF/ID and bubbles EX
    always_comb begin
        if_en     = adv & (jmp_valid | ~hazard);
        id_en     = adv & (jmp_valid | ~hazard);
        ex_en     = adv;
        id_flush  = adv & jmp_valid;
        ex_bubble = adv & ~jmp_valid & hazard;
        pc_nxt    = pc;
        if (adv) begin
            if (jmp_valid)   pc_nxt = jmp_addr;
            else if (!hazard) pc_nxt = pc + 1'b1;
        end
    end

    // State, PC and the one-cycle breakpoint bypass after resuming from HALT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            pc      <= '0;
            skip_bp <= 1'b0;
        end else begin
            state   <= state_nxt;
            pc      <= pc_nxt;
            skip_bp <= (state == HALT) && run_pulse;
        end
    end

    assign running = (state == RUN);
    assign halted  = (state == HALT);

`ifdef PIPE_ADV_COUNT_EN
    logic [15:0] adv_cnt;

    // Saturating count of every advance cycle, stalls and jumps included
    always_ff @(posedge clk) begin
        if (!rst_n)                         adv_cnt <= '0;
        else if (adv && adv_cnt != 16'hFFFF) adv_cnt <= adv_cnt + 16'd1;
    end

    assign adv_count = adv_cnt;
`else
    assign adv_count = 16'd0;
`endif
endmodule

// File: tb/tb_pipeline_step_ctrl.sv
// tb/tb_pipeline_step_ctrl.sv - directed self-checking bench for pipeline_step_ctrl

module tb_pipeline_step_ctrl;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        btn_step;
    logic        btn_run;
    logic        bp_en;
    logic [3:0]  bp_addr;
    logic        hazard;
    logic        jmp_valid;
    logic [3:0]  jmp_addr;
    logic [3:0]  pc;
    logic        if_en;
    logic        id_en;
    logic        ex_en;
    logic        id_flush;
    logic        ex_bubble;
    logic        running;
    logic        halted;
    logic [15:0] adv_count;

    int n_checks = 0;
    int n_fails  = 0;
    int npulse;
    int nbub;
    int first;
    logic en_seen;

    pipeline_step_ctrl #(.DEB_CYCLES(16), .PC_W(4)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .btn_step  (btn_step),
        .btn_run   (btn_run),
        .bp_en     (bp_en),
        .bp_addr   (bp_addr),
        .hazard    (hazard),
        .jmp_valid (jmp_valid),
        .jmp_addr  (jmp_addr),
        .pc        (pc),
        .if_en     (if_en),
        .id_en     (id_en),
        .ex_en     (ex_en),
        .id_flush  (id_flush),
        .ex_bubble (ex_bubble),
        .running   (running),
        .halted    (halted),
        .adv_count (adv_count)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic press_step(input logic hz);
        btn_step = 1'b1;
        hazard   = hz;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ex_en) npulse++;
            if (ex_bubble) nbub++;
        end
        btn_step = 1'b0;
        hazard   = 1'b0;
        for (int i = 0; i < 22; i++) begin
            tick();
            if (ex_en) npulse++;
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; btn_step = 1'b0; btn_run = 1'b0; bp_en = 1'b0; bp_addr = 4'd0;
        hazard = 1'b0; jmp_valid = 1'b0; jmp_addr = 4'd0;
        tick();
        tick();
        chk("rst_pc", 16'(pc), 16'd0);
        chk("rst_en", {13'd0, if_en, id_en, ex_en}, 16'd0);
        chk("rst_flush_bub", {14'd0, id_flush, ex_bubble}, 16'd0);
        chk("rst_run_halt", {14'd0, running, halted}, 16'd0);
        chk("rst_adv_count", adv_count, 16'd0);
        rst_n = 1'b1;

        // single step: pulse appears DEB_CYCLES+3 edges after the raw edge
        btn_step = 1'b1; npulse = 0; first = -1; en_seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (ex_en) begin
                npulse++;
                if (first < 0) first = i;
                en_seen = if_en & id_en;
            end
        end
        chk("step_pulses", 16'(npulse), 16'd1);
        chk("step_latency", 16'(first), 16'd18);
        chk("step_if_id_en", 16'(en_seen), 16'd1);
        chk("step_pc", 16'(pc), 16'd1);

        // release and bounce produce no pulse
        btn_step = 1'b0; npulse = 0;
        for (int i = 0; i < 25; i++) begin tick(); if (ex_en) npulse++; end
        for (int r = 0; r < 2; r++) begin
            btn_step = 1'b1;
            for (int i = 0; i < 5; i++) begin tick(); if (ex_en) npulse++; end
            btn_step = 1'b0;
            for (int i = 0; i < 5; i++) begin tick(); if (ex_en) npulse++; end
        end
        for (int i = 0; i < 25; i++) begin tick(); if (ex_en) npulse++; end
        chk("bounce_pulses", 16'(npulse), 16'd0);
        chk("bounce_pc", 16'(pc), 16'd1);

        // run to breakpoint at 5
        rst_n = 1'b0; tick(); rst_n = 1'b1;
        chk("rst2_pc", 16'(pc), 16'd0);
        bp_en = 1'b1; bp_addr = 4'd5; btn_run = 1'b1;
        repeat (19) tick();
        chk("run_pulse_running", 16'(running), 16'd0);
        chk("run_pulse_no_adv", 16'(ex_en), 16'd0);
        for (int k = 1; k <= 6; k++) begin
            tick();
            if (k == 1) btn_run = 1'b0;
            chk("run_pc_seq", 16'(pc), 16'(k - 1));
            chk("run_adv", 16'(ex_en), (k == 6) ? 16'd0 : 16'd1);
        end
        tick();
        chk("bp_halted", {14'd0, running, halted}, 16'd1);
        chk("bp_pc", 16'(pc), 16'd5);
        repeat (25) tick();
        chk("halt_hold_pc", 16'(pc), 16'd5);
        chk("halt_hold", 16'(halted), 16'd1);

        // resume past the breakpoint
        btn_run = 1'b1;
        repeat (19) tick();
        chk("resume_pulse_halted", 16'(halted), 16'd1);
        chk("resume_pulse_no_adv", 16'(ex_en), 16'd0);
        tick();
        chk("resume_running", 16'(running), 16'd1);
        chk("resume_skip_bp", 16'(ex_en), 16'd1);
        btn_run = 1'b0; bp_en = 1'b0;
        tick();
        chk("resume_pc6", 16'(pc), 16'd6);
        tick();
        chk("resume_pc7", 16'(pc), 16'd7);

        // wrap 15 -> 0
        for (int i = 0; i < 20 && pc != 4'd15; i++) tick();
        chk("reach_pc15", 16'(pc), 16'd15);
        tick();
        chk("wrap_pc0", 16'(pc), 16'd0);

        // hazard stall at pc=3
        for (int i = 0; i < 20 && pc != 4'd3; i++) tick();
        chk("reach_pc3", 16'(pc), 16'd3);
        hazard = 1'b1; #1;
        chk("haz_if_id_en", {14'd0, if_en, id_en}, 16'd0);
        chk("haz_ex_en_bub", {14'd0, ex_en, ex_bubble}, 16'd3);
        tick();
        hazard = 1'b0; #1;
        chk("haz_pc_held", 16'(pc), 16'd3);
        chk("post_haz_en", {13'd0, if_en, id_en, ex_bubble}, 16'd6);
        tick();
        chk("post_haz_pc4", 16'(pc), 16'd4);

        // jump with simultaneous hazard
        jmp_valid = 1'b1; jmp_addr = 4'd9; hazard = 1'b1; #1;
        chk("jmp_flush_bub", {14'd0, id_flush, ex_bubble}, 16'd2);
        chk("jmp_en", {13'd0, if_en, id_en, ex_en}, 16'd7);
        tick();
        jmp_valid = 1'b0; hazard = 1'b0; #1;
        chk("jmp_pc9", 16'(pc), 16'd9);
        chk("jmp_flush_clear", 16'(id_flush), 16'd0);

        // reset in the middle of RUN
        rst_n = 1'b0;
        tick();
        chk("midrun_rst_state", {14'd0, running, halted}, 16'd0);
        chk("midrun_rst_pc", 16'(pc), 16'd0);
        chk("midrun_rst_en", {11'd0, if_en, id_en, ex_en, id_flush, ex_bubble}, 16'd0);
        chk("midrun_rst_cnt", adv_count, 16'd0);
        rst_n = 1'b1;
        tick();
        chk("idle_pc_hold", 16'(pc), 16'd0);

        // ten steps, one with hazard held (only the advance cycle bubbles)
        npulse = 0; nbub = 0;
        for (int p = 0; p < 10; p++) press_step(p == 4);
        chk("ten_steps_pulses", 16'(npulse), 16'd10);
        chk("ten_steps_bubbles", 16'(nbub), 16'd1);
        chk("ten_steps_pc", 16'(pc), 16'd9);
`ifdef PIPE_ADV_COUNT_EN
        chk("adv_count_ten", adv_count, 16'd10);
`else
        chk("adv_count_zero", adv_count, 16'd0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
